fetch_unit: RTL and testbench

- Next-generation instruction fetch stage, replacing the single-cycle PC register with a decoupled fetch pipeline.
- Holds the fetch PC and issues requests to a variable-latency instruction memory with a req/gnt/rvalid handshake.
- Tracks in-flight requests and buffers returned instructions in a parametrised queue toward decode (valid/ready).
- Handles branch, jump, register-jump, ERET and exception redirects, flushing stale instructions.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the decoupled fetch stage:
// redirect sources, default vectors, data width.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] SRC_BR   = 3'd1;
  localparam logic [2:0] SRC_J    = 3'd2;
  localparam logic [2:0] SRC_JR   = 3'd3;
  localparam logic [2:0] SRC_ERET = 3'd4;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_EXC_VEC  = 32'h0000_4180;

  function automatic logic src_legal(
    input logic [2:0] s
  );
    return (s == SRC_BR) || (s == SRC_J) ||
           (s == SRC_JR) || (s == SRC_ERET);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bundles: instruction memory
// req/gnt/rvalid port and decode valid/ready port.
interface fetch_imem_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

interface fetch_dec_if;
  import fetch_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_ready;

  modport master (
    output if_valid, if_instr, if_pc,
    input  if_ready
  );

  modport slave (
    input  if_valid, if_instr, if_pc,
    output if_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; a push into a
// full FIFO is accepted when a pop happens alongside.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: PC, in-flight tracking,
// instruction queue and redirect/flush handling.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] EXC_VEC  = DEF_EXC_VEC,
  parameter int FQ_DEPTH = 2,
  parameter int MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req,
  input  logic            redir_valid,
  input  logic [2:0]      redir_src,
  input  logic [XLEN-1:0] redir_pc,
  input  logic [XLEN-1:0] imm32,
  input  logic [25:0]     instr_idx,
  input  logic [XLEN-1:0] reg_target,
  input  logic [XLEN-1:0] epc,
  fetch_imem_if.master    imem,
  fetch_dec_if.master     dec,
  output logic            redir_err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(MAX_OUT + 1);
  localparam int QW = $clog2(FQ_DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   infl_q, infl_d;
  logic [OW-1:0]   kill_q, kill_d;
  logic            err_q, err_d;

  logic            legal, redirect, issue;
  logic            rvalid, kill_dec;
  logic            fq_push, fq_pop;
  logic [31:0]     committed;
  logic [XLEN-1:0] tag_pc;
  logic [63:0]     fq_head;
  logic            fq_empty, fq_full;
  logic [QW-1:0]   fq_cnt;
  logic            tag_full, tag_empty;
  logic [TW-1:0]   tag_cnt;
  logic            unused_ok;

  assign legal    = redir_valid && src_legal(redir_src);
  assign redirect = exc_req || legal;
  assign rvalid   = imem.imem_rvalid;
  assign kill_dec = rvalid && (kill_q != '0);

  // Live responses plus queued words must fit the queue.
  assign committed = 32'(infl_q) - 32'(kill_q)
                   + 32'(fq_cnt);

  assign imem.imem_req  = rst && !redirect &&
                          (infl_q < OW'(MAX_OUT)) &&
                          (committed < 32'(FQ_DEPTH));
  assign imem.imem_addr = pc_q;
  assign issue = imem.imem_req && imem.imem_gnt;

  assign fq_push = rvalid && (kill_q == '0) && !redirect;
  assign fq_pop  = dec.if_valid && dec.if_ready;

  assign infl_d = infl_q + OW'(issue) - OW'(rvalid);
  // Everything still outstanding after a redirect is stale.
  assign kill_d = redirect ? infl_d
                           : kill_q - OW'(kill_dec);
  assign err_d  = redir_valid && !src_legal(redir_src);

  always_comb begin
    pc_d = pc_q;
    if (exc_req) begin
      pc_d = EXC_VEC;
    end else if (legal) begin
      unique case (redir_src)
        SRC_BR:   pc_d = redir_pc + {imm32[29:0], 2'b00};
        SRC_J:    pc_d = {redir_pc[31:28], instr_idx, 2'b00};
        SRC_JR:   pc_d = reg_target;
        SRC_ERET: pc_d = epc;
        default:  pc_d = pc_q;
      endcase
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      infl_q <= '0;
      kill_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      infl_q <= infl_d;
      kill_q <= kill_d;
      err_q  <= err_d;
    end
  end

  fetch_fifo #(.DEPTH(MAX_OUT), .WIDTH(XLEN)) u_tag (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (rvalid),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_cnt)
  );

  fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH(64)) u_iq (
    .clk   (clk),
    .rst   (rst),
    .push  (fq_push),
    .pop   (fq_pop),
    .flush (redirect),
    .wdata ({tag_pc, imem.imem_rdata}),
    .rdata (fq_head),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_cnt)
  );

  assign dec.if_valid = !fq_empty;
  assign dec.if_instr = fq_empty ? '0 : fq_head[31:0];
  assign dec.if_pc    = fq_empty ? '0 : fq_head[63:32];
  assign redir_err    = err_q;

  assign unused_ok = ^{tag_full, tag_empty, tag_cnt,
                       fq_full, imm32[31:30]};

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with
// programmable latency, expected PC stream queue.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_req = 1'b0;
  logic        redir_valid = 1'b0;
  logic [2:0]  redir_src = 3'd0;
  logic [31:0] redir_pc = '0;
  logic [31:0] imm32 = '0;
  logic [25:0] instr_idx = '0;
  logic [31:0] reg_target = '0;
  logic [31:0] epc = '0;
  logic        redir_err;

  always #5 clk = ~clk;

  fetch_imem_if imem ();
  fetch_dec_if  dec ();

  fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .EXC_VEC  (32'h0000_4180),
    .FQ_DEPTH (2),
    .MAX_OUT  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exc_req     (exc_req),
    .redir_valid (redir_valid),
    .redir_src   (redir_src),
    .redir_pc    (redir_pc),
    .imm32       (imm32),
    .instr_idx   (instr_idx),
    .reg_target  (reg_target),
    .epc         (epc),
    .imem        (imem),
    .dec         (dec),
    .redir_err   (redir_err)
  );

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          budget = 0;
  bit          gnt_rand = 1'b0;
  bit          hold_q = 1'b0;
  logic [31:0] hold_addr = '0;

  function automatic logic [31:0] ins(
    input logic [31:0] a
  );
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  initial begin : bfm
    logic [31:0] e;
    imem.imem_gnt    = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;
    dec.if_ready     = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst) begin
        pend.delete();
        imem.imem_rvalid = 1'b0;
        hold_q = 1'b0;
      end else if (pend.size() != 0 &&
                   pend[0].due <= cyc) begin
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = ins(pend[0].a);
        pend.delete(0);
      end else begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = $urandom;
      end
      imem.imem_gnt = gnt_rand ?
        1'($urandom_range(0, 1)) : 1'b1;
      dec.if_ready = (budget != 0);
      #3;
      if (rst) begin
        if (hold_q && imem.imem_req)
          chk("addr_hold", 64'(imem.imem_addr),
              64'(hold_addr));
        hold_q    = imem.imem_req && !imem.imem_gnt;
        hold_addr = imem.imem_addr;
        if (imem.imem_req && imem.imem_gnt)
          pend.push_back('{a: imem.imem_addr,
                           due: cyc + lat});
        if (dec.if_valid && dec.if_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_pop", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("if_pc", 64'(dec.if_pc), 64'(e));
            chk("if_instr", 64'(dec.if_instr),
                64'(ins(e)));
          end
          if (budget > 0) budget--;
        end
      end
    end
  end

  task automatic push_seq(
    input logic [31:0] base,
    input int          n
  );
    for (int k = 0; k < n; k++)
      exp_q.push_back(base + 32'(4 * k));
    budget = n;
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++)
      @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic drive_redir(
    input logic        exc,
    input logic [2:0]  src,
    input logic [31:0] rpc,
    input logic [31:0] imm,
    input logic [25:0] idx,
    input logic [31:0] rt,
    input logic [31:0] ep
  );
    @(negedge clk);
    exc_req     = exc;
    redir_valid = 1'b1;
    redir_src   = src;
    redir_pc    = rpc;
    imm32       = imm;
    instr_idx   = idx;
    reg_target  = rt;
    epc         = ep;
    #2;
    chk("req_in_redir", 64'(imem.imem_req), 64'd0);
  endtask

  task automatic end_redir(input logic [31:0] tgt);
    @(negedge clk);
    exc_req     = 1'b0;
    redir_valid = 1'b0;
    #2;
    chk("redir_addr", 64'(imem.imem_addr), 64'(tgt));
    chk("flush_valid", 64'(dec.if_valid), 64'd0);
  endtask

  task automatic illegal(input logic [2:0] src);
    @(negedge clk);
    redir_valid = 1'b1;
    redir_src   = src;
    #2;
    chk("err_pre", 64'(redir_err), 64'd0);
    @(negedge clk);
    redir_valid = 1'b0;
    #2;
    chk("err_pulse", 64'(redir_err), 64'd1);
    @(negedge clk);
    #2;
    chk("err_clear", 64'(redir_err), 64'd0);
  endtask

  initial begin : stim
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", 64'(dec.if_valid), 64'd0);
    chk("rst_req", 64'(imem.imem_req), 64'd0);
    chk("rst_addr", 64'(imem.imem_addr), 64'h3000);
    chk("rst_instr", 64'(dec.if_instr), 64'd0);
    chk("rst_pc", 64'(dec.if_pc), 64'd0);
    chk("rst_err", 64'(redir_err), 64'd0);

    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("first_req", 64'(imem.imem_req), 64'd1);
    chk("first_addr", 64'(imem.imem_addr), 64'h3000);
    push_seq(32'h3000, 3);
    wait_drain(60);

    repeat (8) @(negedge clk);
    #2;
    chk("bp_req", 64'(imem.imem_req), 64'd0);
    chk("bp_addr", 64'(imem.imem_addr), 64'h3014);

    lat = 3;
    push_seq(32'h300c, 2);
    wait_drain(60);
    drive_redir(1'b0, SRC_BR, 32'h3010, 32'h4,
                '0, '0, '0);
    chk("outstanding", 64'(pend.size()), 64'd2);
    end_redir(32'h3020);
    push_seq(32'h3020, 3);
    wait_drain(80);

    lat = 1;
    drive_redir(1'b1, SRC_JR, '0, '0, '0,
                32'h5000, '0);
    end_redir(32'h4180);
    push_seq(32'h4180, 3);
    wait_drain(60);

    drive_redir(1'b0, SRC_ERET, '0, '0, '0,
                '0, 32'h3100);
    end_redir(32'h3100);
    push_seq(32'h3100, 2);
    wait_drain(60);

    drive_redir(1'b0, SRC_J, 32'hA000_0104, '0,
                26'h000_1234, '0, '0);
    end_redir(32'hA000_48D0);
    push_seq(32'hA000_48D0, 2);
    wait_drain(60);

    drive_redir(1'b0, SRC_BR, 32'h0000_0004,
                32'hFFFF_FFFC, '0, '0, '0);
    end_redir(32'hFFFF_FFF4);
    push_seq(32'hFFFF_FFF4, 2);
    wait_drain(60);

    drive_redir(1'b0, SRC_BR, 32'h100, 32'h8,
                '0, '0, '0);
    drive_redir(1'b0, SRC_JR, '0, '0, '0,
                32'h6000, '0);
    end_redir(32'h6000);
    push_seq(32'h6000, 2);
    wait_drain(60);

    repeat (4) @(negedge clk);
    illegal(3'd0);
    illegal(3'd7);
    gnt_rand = 1'b1;
    push_seq(32'h6008, 4);
    wait_drain(200);
    gnt_rand = 1'b0;

    lat = 3;
    repeat (6) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(dec.if_valid), 64'd0);
    chk("arst_req", 64'(imem.imem_req), 64'd0);
    chk("arst_addr", 64'(imem.imem_addr), 64'h3000);
    exp_q.delete();
    budget = 0;
    repeat (2) @(negedge clk);
    lat = 1;
    rst = 1'b1;
    push_seq(32'h3000, 3);
    wait_drain(60);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
